// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - instruction/type ids, MIPS opcode/funct constants and decoded entry type
//
// Shared by instr_classifier and decode_buffer. No ports.
//   ID_*        bit positions in the one-hot instr_tb vector
//   T_*         bit positions in the type_tb flag vector
//   OP_*/FN_*   MIPS opcode [31:26] and R-type funct [5:0] values
//   decoded_t   {instr_tb, type_tb, illegal} as stored with each queue entry
package decode_pkg;

   localparam int ID_ADD  = 0;
   localparam int ID_SUB  = 1;
   localparam int ID_AND  = 2;
   localparam int ID_OR   = 3;
   localparam int ID_XOR  = 4;
   localparam int ID_NOR  = 5;
   localparam int ID_SLT  = 6;
   localparam int ID_JR   = 7;
   localparam int ID_SLL  = 8;
   localparam int ID_SRL  = 9;
   localparam int ID_SRA  = 10;
   localparam int ID_SW   = 11;
   localparam int ID_LW   = 12;
   localparam int ID_ADDI = 13;
   localparam int ID_ANDI = 14;
   localparam int ID_ORI  = 15;
   localparam int ID_XORI = 16;
   localparam int ID_SLTI = 17;
   localparam int ID_BEQ  = 18;
   localparam int ID_BNE  = 19;
   localparam int ID_J    = 20;
   localparam int ID_JAL  = 21;
   localparam int MAX_INSTR_ID = 21;

   localparam int T_RTYPE  = 0;
   localparam int T_IRTYPE = 1;
   localparam int T_ITYPE  = 2;
   localparam int T_MEM    = 3;
   localparam int T_JTYPE  = 4;
   localparam int T_BRANCH = 5;
   localparam int MAX_TYPE_ID = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SRA = 6'h03;
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef struct packed {
      logic [MAX_INSTR_ID:0] instr_tb;
      logic [MAX_TYPE_ID:0]  type_tb;
      logic                  illegal;
   } decoded_t;

endpackage

// File: rtl/instr_classifier.sv
// rtl/instr_classifier.sv - combinational MIPS (opcode, funct) classifier
//
// Ports:
//   opcode  in  6          instruction bits [31:26]
//   funct   in  6          instruction bits [5:0], only meaningful for R-type
//   dec     out decoded_t  one-hot instr id, type flags, illegal flag
module instr_classifier
   import decode_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output decoded_t   dec
);

   logic [MAX_INSTR_ID:0] id;
   logic                  irtype;
   logic                  mem;
   logic                  jtype;

   always_comb begin
      id = '0;
      if (opcode == OP_RTYPE) begin
         case (funct)
            FN_ADD:  id[ID_ADD] = 1'b1;
            FN_SUB:  id[ID_SUB] = 1'b1;
            FN_AND:  id[ID_AND] = 1'b1;
            FN_OR:   id[ID_OR]  = 1'b1;
            FN_XOR:  id[ID_XOR] = 1'b1;
            FN_NOR:  id[ID_NOR] = 1'b1;
            FN_SLT:  id[ID_SLT] = 1'b1;
            FN_JR:   id[ID_JR]  = 1'b1;
            FN_SLL:  id[ID_SLL] = 1'b1;
            FN_SRL:  id[ID_SRL] = 1'b1;
            FN_SRA:  id[ID_SRA] = 1'b1;
            default: id = '0;
         endcase
      end else begin
         case (opcode)
            OP_SW:   id[ID_SW]   = 1'b1;
            OP_LW:   id[ID_LW]   = 1'b1;
            OP_ADDI: id[ID_ADDI] = 1'b1;
            OP_ANDI: id[ID_ANDI] = 1'b1;
            OP_ORI:  id[ID_ORI]  = 1'b1;
            OP_XORI: id[ID_XORI] = 1'b1;
            OP_SLTI: id[ID_SLTI] = 1'b1;
            OP_BEQ:  id[ID_BEQ]  = 1'b1;
            OP_BNE:  id[ID_BNE]  = 1'b1;
            OP_J:    id[ID_J]    = 1'b1;
            OP_JAL:  id[ID_JAL]  = 1'b1;
            default: id = '0;
         endcase
      end

      irtype = id[ID_ADDI] | id[ID_ANDI] | id[ID_ORI] | id[ID_XORI] | id[ID_SLTI];
      mem    = id[ID_LW] | id[ID_SW];
      jtype  = id[ID_J] | id[ID_JAL];

      dec.instr_tb = id;
      dec.illegal  = (id == '0);
      dec.type_tb  = '0;
      // An unknown funct under opcode 0 is illegal, not R-type.
      dec.type_tb[T_RTYPE]  = (opcode == OP_RTYPE) && (id != '0);
      dec.type_tb[T_IRTYPE] = irtype;
      dec.type_tb[T_MEM]    = mem;
      dec.type_tb[T_ITYPE]  = irtype | mem | id[ID_BEQ] | id[ID_BNE];
      dec.type_tb[T_JTYPE]  = jtype;
      dec.type_tb[T_BRANCH] = jtype | id[ID_BEQ] | id[ID_BNE] | id[ID_JR];
   end

endmodule

// File: rtl/decode_buffer.sv
// rtl/decode_buffer.sv - decode-at-enqueue instruction FIFO between fetch and issue
//
// Optional feature macro: DECODE_BUF_BYPASS_EN (zero-latency empty-queue bypass).
// Ports:
//   clk, reset                      clock, async active-high reset
//   flush                           drop all entries and this cycle's push
//   in_valid/in_ready/in_pc/in_instr  fetch side handshake and payload
//   out_valid/out_ready             issue side handshake
//   out_pc/out_instr/out_instr_tb/out_type_tb/out_illegal  head entry payload (0 when empty)
//   count                           valid entries
//   branch_pending                  at least one stored entry is a branch
module decode_buffer
   import decode_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int PC_WIDTH    = 32,
   parameter int INSTR_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [PC_WIDTH-1:0]        in_pc,
   input  logic [INSTR_WIDTH-1:0]     in_instr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PC_WIDTH-1:0]        out_pc,
   output logic [INSTR_WIDTH-1:0]     out_instr,
   output logic [MAX_INSTR_ID:0]      out_instr_tb,
   output logic [MAX_TYPE_ID:0]       out_type_tb,
   output logic                       out_illegal,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       branch_pending
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef struct packed {
      logic [PC_WIDTH-1:0]    pc;
      logic [INSTR_WIDTH-1:0] instr;
      decoded_t               dec;
   } entry_t;

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d, br_cnt_q, br_cnt_d;

   decoded_t enq_dec;
   entry_t   head_e;
   logic     stored_valid, bypass, push, pop, push_br, pop_br;

   instr_classifier u_enq_cls (
      .opcode (in_instr[31:26]),
      .funct  (in_instr[5:0]),
      .dec    (enq_dec)
   );

`ifdef DECODE_BUF_BYPASS_EN
   decoded_t byp_dec;

   instr_classifier u_byp_cls (
      .opcode (in_instr[31:26]),
      .funct  (in_instr[5:0]),
      .dec    (byp_dec)
   );

   assign bypass = (count_q == '0) & in_valid & out_ready & ~flush;
`else
   assign bypass = 1'b0;
`endif

   assign head_e       = mem_q[head_q];
   assign stored_valid = (count_q != '0);
   // Depends on state only, so a full queue never accepts even when popping.
   assign in_ready     = (count_q != CNT_W'(DEPTH));
   assign out_valid    = stored_valid | bypass;
   assign count        = count_q;
   assign branch_pending = (br_cnt_q != '0);

   // A bypassed word is consumed directly and never written into storage.
   assign push    = in_valid & in_ready & ~flush & ~bypass;
   assign pop     = stored_valid & out_ready & ~flush;
   assign push_br = push & enq_dec.type_tb[T_BRANCH];
   assign pop_br  = pop & head_e.dec.type_tb[T_BRANCH];

   always_comb begin
      out_pc       = '0;
      out_instr    = '0;
      out_instr_tb = '0;
      out_type_tb  = '0;
      out_illegal  = 1'b0;
      if (stored_valid) begin
         out_pc       = head_e.pc;
         out_instr    = head_e.instr;
         out_instr_tb = head_e.dec.instr_tb;
         out_type_tb  = head_e.dec.type_tb;
         out_illegal  = head_e.dec.illegal;
      end
`ifdef DECODE_BUF_BYPASS_EN
      else if (bypass) begin
         out_pc       = in_pc;
         out_instr    = in_instr;
         out_instr_tb = byp_dec.instr_tb;
         out_type_tb  = byp_dec.type_tb;
         out_illegal  = byp_dec.illegal;
      end
`endif
   end

   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      br_cnt_d = br_cnt_q;
      if (flush) begin
         head_d   = '0;
         tail_d   = '0;
         count_d  = '0;
         br_cnt_d = '0;
      end else begin
         if (pop)  head_d = head_q + PTR_W'(1);
         if (push) tail_d = tail_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         case ({push_br, pop_br})
            2'b10:   br_cnt_d = br_cnt_q + CNT_W'(1);
            2'b01:   br_cnt_d = br_cnt_q - CNT_W'(1);
            default: br_cnt_d = br_cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         br_cnt_q <= '0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         br_cnt_q <= br_cnt_d;
      end
   end

   // Storage is not reset; the count gates every read of it.
   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= '{pc: in_pc, instr: in_instr, dec: enq_dec};
   end

endmodule

// File: tb/tb_decode_buffer.sv
// tb/tb_decode_buffer.sv - directed self-checking bench for decode_buffer
module tb_decode_buffer;
   import decode_pkg::*;

   localparam logic [31:0] W_ADD  = 32'h012A4020;
   localparam logic [31:0] W_LW   = 32'h8D090004;
   localparam logic [31:0] W_BEQ  = 32'h11090003;
   localparam logic [31:0] W_J    = 32'h08000040;
   localparam logic [31:0] W_ADDI = 32'h21080001;
   localparam logic [31:0] W_BADOP = 32'hFC000000;
   localparam logic [31:0] W_BADFN = 32'h0000003F;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_pc, in_instr, out_pc, out_instr;
   logic [MAX_INSTR_ID:0] out_instr_tb;
   logic [MAX_TYPE_ID:0]  out_type_tb;
   logic        out_illegal, branch_pending;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;
   logic [31:0] pcq[$];
   logic [31:0] w2[4];
   logic [31:0] p2[4];
   logic [63:0] e_id[4];
   logic [63:0] e_ty[4];
   logic        e_bp[4];

   decode_buffer dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .out_instr_tb(out_instr_tb), .out_type_tb(out_type_tb), .out_illegal(out_illegal),
      .count(count), .branch_pending(branch_pending)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
      #1 reset = 1'b1;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_count", 64'(count), 64'd0);
      check("rst_bp", 64'(branch_pending), 64'd0);
      check("rst_out_pc", 64'(out_pc), 64'd0);
      check("rst_out_tb", 64'(out_instr_tb), 64'd0);
      tick; tick;
      reset = 1'b0;

      // 1: single push, one-cycle latency
      in_valid = 1'b1; in_pc = 32'h100; in_instr = W_ADD;
      #1 check("t1_no_bypass", 64'(out_valid), 64'd0);
      tick;
      in_valid = 1'b0;
      #1;
      check("t1_valid", 64'(out_valid), 64'd1);
      check("t1_id", 64'(out_instr_tb), 64'd1 << ID_ADD);
      check("t1_type", 64'(out_type_tb), 64'd1 << T_RTYPE);
      check("t1_count", 64'(count), 64'd1);
      check("t1_illegal", 64'(out_illegal), 64'd0);
      check("t1_pc", 64'(out_pc), 64'h100);
      check("t1_instr", 64'(out_instr), 64'(W_ADD));
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      #1;
      check("t1_drained", 64'(count), 64'd0);
      check("t1_drained_valid", 64'(out_valid), 64'd0);

      // 2: fill to DEPTH, reject 5th push
      w2 = '{W_LW, W_BEQ, W_J, W_ADDI};
      p2 = '{32'h200, 32'h204, 32'h208, 32'h20C};
      e_id = '{64'd1 << ID_LW, 64'd1 << ID_BEQ, 64'd1 << ID_J, 64'd1 << ID_ADDI};
      e_ty = '{(64'd1 << T_MEM) | (64'd1 << T_ITYPE),
               (64'd1 << T_ITYPE) | (64'd1 << T_BRANCH),
               (64'd1 << T_JTYPE) | (64'd1 << T_BRANCH),
               (64'd1 << T_IRTYPE) | (64'd1 << T_ITYPE)};
      e_bp = '{1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_pc = p2[i]; in_instr = w2[i];
         tick;
      end
      in_valid = 1'b0;
      #1;
      check("t2_count", 64'(count), 64'd4);
      check("t2_in_ready", 64'(in_ready), 64'd0);
      check("t2_bp", 64'(branch_pending), 64'd1);
      in_valid = 1'b1; in_pc = 32'h300; in_instr = W_ADD;
      tick;
      in_valid = 1'b0;
      #1;
      check("t2_full_count", 64'(count), 64'd4);
      check("t2_full_head", 64'(out_pc), 64'h200);

      // 3: drain in order
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("t3_pc%0d", i), 64'(out_pc), 64'(p2[i]));
         check($sformatf("t3_id%0d", i), 64'(out_instr_tb), e_id[i]);
         check($sformatf("t3_type%0d", i), 64'(out_type_tb), e_ty[i]);
         tick;
         check($sformatf("t3_bp%0d", i), 64'(branch_pending), 64'(e_bp[i]));
         check($sformatf("t3_count%0d", i), 64'(count), 64'(3 - i));
      end
      out_ready = 1'b0;
      #1 check("t3_empty", 64'(out_valid), 64'd0);

      // 4: illegal opcode, then illegal R-type funct with simultaneous push/pop
      in_valid = 1'b1; in_pc = 32'h400; in_instr = W_BADOP;
      tick;
      in_valid = 1'b0;
      #1;
      check("t4_op_illegal", 64'(out_illegal), 64'd1);
      check("t4_op_id", 64'(out_instr_tb), 64'd0);
      check("t4_op_type", 64'(out_type_tb), 64'd0);
      in_valid = 1'b1; in_pc = 32'h404; in_instr = W_BADFN; out_ready = 1'b1;
      tick;
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      check("t4_pp_count", 64'(count), 64'd1);
      check("t4_fn_pc", 64'(out_pc), 64'h404);
      check("t4_fn_illegal", 64'(out_illegal), 64'd1);
      check("t4_fn_id", 64'(out_instr_tb), 64'd0);
      check("t4_fn_type", 64'(out_type_tb), 64'd0);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      #1 check("t4_drained", 64'(count), 64'd0);

      // 5: steady count=3 across pointer wrap, then flush with a push
      pcq.delete();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_pc = 32'h1000 + 32'(4 * i); in_instr = (i % 2 == 1) ? W_BEQ : W_ADD;
         pcq.push_back(in_pc);
         tick;
      end
      out_ready = 1'b1;
      for (int i = 3; i < 23; i++) begin
         in_valid = 1'b1; in_pc = 32'h1000 + 32'(4 * i); in_instr = (i % 2 == 1) ? W_BEQ : W_ADD;
         #1 check($sformatf("t5_head%0d", i), 64'(out_pc), 64'(pcq[0]));
         tick;
         void'(pcq.pop_front());
         pcq.push_back(32'h1000 + 32'(4 * i));
         check($sformatf("t5_count%0d", i), 64'(count), 64'd3);
      end
      check("t5_bp_before", 64'(branch_pending), 64'd1);
      flush = 1'b1; in_valid = 1'b1; in_pc = 32'h2000; in_instr = W_BEQ;
      tick;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      check("t5_fl_count", 64'(count), 64'd0);
      check("t5_fl_valid", 64'(out_valid), 64'd0);
      check("t5_fl_bp", 64'(branch_pending), 64'd0);
      check("t5_fl_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1; in_pc = 32'h2100; in_instr = W_ADD;
      tick;
      in_valid = 1'b0;
      #1;
      check("t5_post_pc", 64'(out_pc), 64'h2100);
      check("t5_post_count", 64'(count), 64'd1);

      // 6: async reset mid-stream with count=2
      in_valid = 1'b1; in_pc = 32'h2104; in_instr = W_J;
      tick;
      in_valid = 1'b0;
      #1 check("t6_pre_count", 64'(count), 64'd2);
      #2 reset = 1'b1;
      #1;
      check("t6_rst_valid", 64'(out_valid), 64'd0);
      check("t6_rst_count", 64'(count), 64'd0);
      check("t6_rst_bp", 64'(branch_pending), 64'd0);
      tick;
      reset = 1'b0;
      in_valid = 1'b1; in_pc = 32'h3000; in_instr = W_ADDI;
      tick;
      in_valid = 1'b0;
      #1;
      check("t6_after_pc", 64'(out_pc), 64'h3000);
      check("t6_after_count", 64'(count), 64'd1);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      #1 check("t6_drained", 64'(count), 64'd0);

`ifdef DECODE_BUF_BYPASS_EN
      in_valid = 1'b1; in_pc = 32'h500; in_instr = W_J; out_ready = 1'b1;
      #1;
      check("byp_valid", 64'(out_valid), 64'd1);
      check("byp_pc", 64'(out_pc), 64'h500);
      check("byp_type", 64'(out_type_tb), (64'd1 << T_JTYPE) | (64'd1 << T_BRANCH));
      check("byp_ready", 64'(in_ready), 64'd1);
      tick;
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      check("byp_count", 64'(count), 64'd0);
      check("byp_bp", 64'(branch_pending), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
